// File: rtl/fetch_stage_queue.sv
// fetch_stage_queue
// In-order DEPTH-entry queue between F1 PC select and F2 I-cache access.
// Each entry carries the fetch PC and any pending I-cache operation. At most
// one cache operation is queued at a time. A restart window keeps
// out_XOP_Restart high for RESTART_CYC dequeues, starting with the cache-op
// entry itself.
module fetch_stage_queue #(
  parameter int PCW         = 32,
  parameter int PABITS      = 36,
  parameter int DEPTH       = 2,
  parameter int RESTART_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PCW-1:0]               in_PC,
  input  logic                         in_DoICacheOp,
  input  logic [2:0]                   in_ICacheOp,
  input  logic [PABITS-11:0]           in_ICacheOpData,
  input  logic                         in_XOP_Restart,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PCW-1:0]               out_PC,
  output logic                         out_DoICacheOp,
  output logic [2:0]                   out_ICacheOp,
  output logic [PABITS-11:0]           out_ICacheOpData,
  output logic                         out_XOP_Restart,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int DW = PABITS - 10;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           do_op;
    logic [2:0]     op;
    logic [DW-1:0]  op_data;
    logic           xop;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_next;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [3:0]       rcnt;
  logic             op_pending;
  logic             enq;
  logic             deq;
  entry_t           head_e;
  entry_t           in_e;

  // Pointer advance, wrapping modulo DEPTH.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_e = '{pc: in_PC, do_op: in_DoICacheOp, op: in_ICacheOp,
                  op_data: in_ICacheOpData, xop: in_XOP_Restart};
  assign head_e = mem[head];

  // Any occupied slot holding a cache op blocks further enqueues.
  always_comb begin
    op_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      op_pending = op_pending | (vld[i] & mem[i].do_op);
    end
  end

  assign out_valid = (count != '0);
  assign in_ready  = flush | (((count < CW'(DEPTH)) | out_ready) & ~op_pending);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready & ~flush;

  // Slot occupancy after this cycle's handshakes; the enqueue is applied last
  // so a full-queue passthrough reuses the freed head slot.
  always_comb begin
    // NOTE: temporaries in combinational blocks use blocking '=', with a full
    // default first so no latch is inferred.
    vld_next = vld;
    if (deq) vld_next[head] = 1'b0;
    if (enq) vld_next[tail] = 1'b1;
  end

  // Entry storage: written at the tail, or at slot 0 when a flush restarts
  // the queue with the incoming entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: storage is reset on purpose so the out_* fields read zero after
    // reset; this is a small register file, not a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      if (in_valid) mem[0] <= in_e;
    end else if (enq) begin
      mem[tail] <= in_e;
    end
  end

  // Pointers, occupancy and restart window; flush overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all sequential state uses non-blocking '<=' so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      rcnt  <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= in_valid ? nxt('0) : '0;
      count <= in_valid ? CW'(1) : '0;
      vld   <= in_valid ? DEPTH'(1) : '0;
      rcnt  <= '0;
    end else begin
      if (enq) tail <= nxt(tail);
      if (deq) head <= nxt(head);
      count <= count + CW'(enq) - CW'(deq);
      vld   <= vld_next;
      if (deq) begin
        if (head_e.do_op)     rcnt <= 4'(RESTART_CYC - 1);
        else if (rcnt != '0) rcnt <= rcnt - 4'd1;
      end
    end
  end

  // Head entry fields and the stretched restart indication.
  assign out_PC           = head_e.pc;
  assign out_DoICacheOp   = head_e.do_op;
  assign out_ICacheOp     = head_e.op;
  assign out_ICacheOpData = head_e.op_data;
  assign out_XOP_Restart  = out_valid & (head_e.xop | head_e.do_op | (rcnt != '0));

endmodule

// File: tb/tb_fetch_stage_queue.sv
// Testbench for fetch_stage_queue (DEPTH = 2, RESTART_CYC = 3).
// Stimulus pushes the expected head fields for each accepted entry into a
// scoreboard; a monitor pops and compares on every dequeue.
module tb_fetch_stage_queue;

  localparam int PCW = 32;
  localparam int PABITS = 36;
  localparam int DW = PABITS - 10;
  localparam int DEPTH = 2;
  localparam int RCYC = 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [PCW-1:0] in_PC = '0;
  logic           in_DoICacheOp = 1'b0;
  logic [2:0]     in_ICacheOp = '0;
  logic [DW-1:0]  in_ICacheOpData = '0;
  logic           in_XOP_Restart = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PCW-1:0] out_PC;
  logic           out_DoICacheOp;
  logic [2:0]     out_ICacheOp;
  logic [DW-1:0]  out_ICacheOpData;
  logic           out_XOP_Restart;
  logic [CW-1:0]  count;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           do_op;
    logic [2:0]     op;
    logic [DW-1:0]  data;
    logic           rst;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_stage_queue #(.PCW(PCW), .PABITS(PABITS), .DEPTH(DEPTH), .RESTART_CYC(RCYC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_PC(in_PC),
    .in_DoICacheOp(in_DoICacheOp), .in_ICacheOp(in_ICacheOp),
    .in_ICacheOpData(in_ICacheOpData), .in_XOP_Restart(in_XOP_Restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC),
    .out_DoICacheOp(out_DoICacheOp), .out_ICacheOp(out_ICacheOp),
    .out_ICacheOpData(out_ICacheOpData), .out_XOP_Restart(out_XOP_Restart),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache-op fields are a fixed function of the PC so each entry is distinct.
  function automatic logic [2:0] op_of(input logic [PCW-1:0] pc);
    return pc[4:2] ^ 3'b101;
  endfunction
  function automatic logic [DW-1:0] data_of(input logic [PCW-1:0] pc);
    return DW'(pc) ^ 26'h2a5_5a5a;
  endfunction

  // One cycle: drive after the rising edge, check at the falling edge, and
  // queue the expected head if the entry should be accepted.
  task automatic drive(input logic v, input logic [PCW-1:0] pc, input logic op,
                       input logic xop, input logic ordy, input logic fl,
                       input logic exp_rdy, input int exp_cnt, input logic exp_rst);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid        = v;
    in_PC           = pc;
    in_DoICacheOp   = op;
    in_ICacheOp     = op_of(pc);
    in_ICacheOpData = data_of(pc);
    in_XOP_Restart  = xop;
    out_ready       = ordy;
    flush           = fl;
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("count", 64'(count), 64'(exp_cnt));
    if (fl) sb.delete();
    if (v && exp_rdy) begin
      e.pc = pc; e.do_op = op; e.op = op_of(pc); e.data = data_of(pc); e.rst = exp_rst;
      sb.push_back(e);
    end
  endtask

  // Monitor: every cycle that will dequeue, compare the head with the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_dequeue", 64'(out_PC), 64'hdead);
      end else begin
        e = sb.pop_front();
        check("out_PC", 64'(out_PC), 64'(e.pc));
        check("out_DoICacheOp", 64'(out_DoICacheOp), 64'(e.do_op));
        if (e.do_op) begin
          check("out_ICacheOp", 64'(out_ICacheOp), 64'(e.op));
          check("out_ICacheOpData", 64'(out_ICacheOpData), 64'(e.data));
        end
        check("out_XOP_Restart", 64'(out_XOP_Restart), 64'(e.rst));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_PC", 64'(out_PC), 64'd0);
    check("rst_out_xop", 64'(out_XOP_Restart), 64'd0);
    #10 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Fill/drain: third enqueue refused while full, then retried with out_ready.
    //     v  pc      op   xop  ordy fl   rdy  cnt rst
    drive(1, 'h100, 0,   0,   0,   0,   1,   0,  0);
    drive(1, 'h104, 0,   0,   0,   0,   1,   1,  0);
    drive(1, 'h108, 0,   0,   0,   0,   0,   2,  0);
    drive(1, 'h108, 0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   1,  0);
    drive(0, 'h0,   0,   0,   0,   0,   1,   0,  0);

    // Full passthrough: 0x100 leaves, 0x200 enters, count stays 2.
    drive(1, 'h100, 0,   0,   0,   0,   1,   0,  0);
    drive(1, 'h104, 0,   0,   0,   0,   1,   1,  0);
    drive(1, 'h200, 0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   0,   0,   0,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   1,  0);
    drive(0, 'h0,   0,   0,   0,   0,   1,   0,  0);

    // Cache-op serialisation and a three-dequeue restart window.
    drive(1, 'h2fc, 1,   0,   0,   0,   1,   0,  1);
    drive(1, 'h300, 0,   0,   0,   0,   0,   1,  0);
    drive(1, 'h300, 0,   0,   0,   0,   0,   1,  0);
    drive(1, 'h300, 0,   0,   1,   0,   0,   1,  0);
    drive(1, 'h300, 0,   0,   0,   0,   1,   0,  1);
    drive(1, 'h304, 0,   0,   0,   0,   1,   1,  1);
    drive(1, 'h308, 0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   2,  0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   1,  0);
    drive(0, 'h0,   0,   0,   0,   0,   1,   0,  0);

    // Flush with an incoming entry while a restart window is open.
    drive(1, 'h3f0, 1,   0,   0,   0,   1,   0,  1);
    drive(0, 'h0,   0,   0,   1,   0,   0,   1,  0);
    drive(1, 'h380, 0,   0,   0,   0,   1,   0,  1);
    drive(1, 'h384, 0,   0,   0,   0,   1,   1,  1);
    drive(1, 'h400, 0,   0,   1,   1,   1,   2,  0);
    drive(0, 'h0,   0,   0,   0,   0,   1,   1,  0);
    check("flush_out_PC", 64'(out_PC), 64'h400);
    check("flush_rcnt_clear", 64'(out_XOP_Restart), 64'd0);
    drive(0, 'h0,   0,   0,   1,   0,   1,   1,  0);

    // Entry carrying its own XOP restart request.
    drive(1, 'h500, 0,   1,   0,   0,   1,   0,  1);
    drive(0, 'h0,   0,   0,   1,   0,   1,   1,  0);
    drive(0, 'h0,   0,   0,   0,   0,   1,   0,  0);

    // Asynchronous reset with two entries queued.
    drive(1, 'h600, 0,   0,   0,   0,   1,   0,  0);
    drive(1, 'h604, 0,   0,   0,   0,   1,   1,  0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_PC", 64'(out_PC), 64'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    #1 check("arst_in_ready", 64'(in_ready), 64'd1);
    drive(0, 'h0,   0,   0,   0,   0,   1,   0,  0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
